mul_seq_31x32: RTL and testbench
================================

Name: mul_seq_31x32

Overview:
- Sequencing controller that computes a signed 31x32 product by driving a 31x8 signed slice multiplier four times and accumulating the shifted slice products.
- Sits between a requester with a valid/ready operand interface and a downstream consumer with a valid/ready result interface.
- Owns the operand registers, slice counter, accumulator and the handshake FSM.
- Reuse of the team's 31x8 Booth carry-save core plus a final 38-bit add per slice is permitted.

Parameters:
- A_W, 31, multiplicand width (two's complement); fixed by the slice core.
- SLICE_W, 8, multiplier bits consumed per cycle.
- B_W, 32, multiplier width (two's complement); must be a multiple of SLICE_W; NSLICE = B_W/SLICE_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- in_a  input  A_W  multiplicand, signed.
- in_b  input  B_W  multiplier, signed.
- abort  input  1  cancel any in-flight operation.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_p  output  A_W+B_W  signed product (63 bits at defaults).
- busy  output  1  high in RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, slice counter k=0, accumulator=0, out_p=0, out_valid=0, busy=0. in_ready follows the state, so it is 1 in IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready; there is no path from in_valid to in_ready.
- Accept: on a rising edge with in_valid & in_ready & !abort:
  - latch in_a and in_b;
  - clear the accumulator;
  - set k=0 and go to RUN.
- RUN, one slice per clock, k = 0..NSLICE-1:
  - digit d_k = in_b[8k+7:8k]. It is zero-extended for k < NSLICE-1 and sign-extended for k = NSLICE-1.
  - acc <= acc + sext(a * d_k) << (8k).
  - Accumulator width is A_W+B_W; overflow is impossible.
  - On the edge completing k = NSLICE-1: out_p <= final acc, out_valid <= 1, state -> DONE.
  - Latency from the accept edge to out_valid high: NSLICE edges (4 at defaults).
- DONE:
  - out_valid=1 and out_p stable until an edge with out_ready=1.
  - On that edge, with a new accept in the same cycle: go to RUN (back-to-back, no bubble).
  - Otherwise: go to IDLE with out_valid <= 0.
  - out_p keeps its last value after the handshake; consumers must qualify it with out_valid.
- abort has priority over every other event:
  - In RUN: go to IDLE on the next edge and discard the accumulator. No out_valid is produced.
  - In DONE: the pending result is dropped; out_valid <= 0.
  - An abort coinciding with an accept means the operands are not taken.
  - In IDLE: no effect.
- busy = (state==RUN).
- Inputs in_a and in_b are sampled only on the accept edge. Changes during RUN have no effect.
- Reset mid-RUN or mid-DONE returns all outputs to reset values immediately. No partial result is ever emitted.

Test Plan:
1. a=1, b=1 -> out_valid rises 4 edges after accept; out_p = 0x0000_0000_0000_0001; busy high for exactly 4 cycles.
2. a=0x7FFF_FFFF (-1), b=0x0000_0001 -> out_p = 0x7FFF_FFFF_FFFF_FFFF (-1 in 63 bits). a=0x3FFF_FFFF, b=0x7FFF_FFFF -> out_p = 0x1FFF_FFFF_4000_0001.
3. a=0x4000_0000 (-2^30), b=0x8000_0000 (-2^31) -> out_p = 0x2000_0000_0000_0000. a=0x4000_0000, b=0x0000_00FF -> out_p = -255*2^30, confirming slice 0 is treated as unsigned.
4. Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_p stable, in_ready=0. Then raise out_ready with in_valid=1 and new operands -> result accepted and new op starts RUN on the same edge; the next result arrives 4 edges later.
5. Abort at k=2 -> IDLE next edge, no out_valid, in_ready=1. Abort in DONE -> out_valid drops with no handshake.
6. Async rst pulse mid-RUN, asserted between clock edges -> out_valid=0, busy=0, out_p=0 immediately. The first accept after release produces a correct product (a=3, b=-2 -> 0x7FFF_FFFF_FFFF_FFFA).

Source files
------------

// File: rtl/mul_seq_31x32.sv
// mul_seq_31x32: signed A_W x B_W multiplier built from NSLICE passes of a
// signed A_W x SLICE_W slice product, accumulated with per-slice shifts.
// Operands arrive over a valid/ready interface, and the product leaves over
// another valid/ready interface. abort cancels any operation in flight.
module mul_seq_31x32 #(
    parameter int A_W     = 31,
    parameter int SLICE_W = 8,
    parameter int B_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   out_p,
    output logic                 busy
);

    localparam int NSLICE = B_W / SLICE_W;
    localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int P_W    = A_W + B_W;
    localparam int SH_W   = $clog2(B_W);
    localparam int SP_W   = A_W + SLICE_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q;
    logic [A_W-1:0]    a_q;
    logic [B_W-1:0]    b_q;
    logic [K_W-1:0]    k_q;
    logic [P_W-1:0]    acc_q;
    logic [P_W-1:0]    acc_d;
    logic [P_W-1:0]    p_q;
    logic              valid_q;

    logic [SH_W-1:0]        shamt;
    logic [SLICE_W-1:0]     dig_raw;
    logic                   last_slice;
    logic [SLICE_W:0]       dig;
    logic signed [SP_W-1:0] prod;
    logic [P_W-1:0]         term;
    logic                   accept;

    // Slice datapath. The digit becomes a (SLICE_W+1)-bit signed value:
    // lower slices are unsigned radix-2^SLICE_W digits, and only the top slice
    // carries the multiplier's sign bit.
    always_comb begin
        shamt      = SH_W'(k_q) * SH_W'(SLICE_W);
        dig_raw    = b_q[shamt +: SLICE_W];
        last_slice = (k_q == K_W'(NSLICE - 1));
        dig        = {last_slice & dig_raw[SLICE_W-1], dig_raw};
        prod       = $signed({{(SLICE_W + 1){a_q[A_W-1]}}, a_q})
                   * $signed({{A_W{dig[SLICE_W]}}, dig});
        term       = {{(P_W - SP_W){prod[SP_W-1]}}, prod} << shamt;
        acc_d      = acc_q + term;
    end

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~abort;
    assign busy      = (state_q == RUN);
    assign out_valid = valid_q;
    assign out_p     = p_q;

    // Handshake FSM, slice sequencing and result registers. abort wins over all other events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + K_W'(1);
                        if (last_slice) begin
                            p_q     <= acc_d;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            a_q     <= in_a;
                            b_q     <= in_b;
                            acc_q   <= '0;
                            k_q     <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_31x32.sv
// Self-checking bench for mul_seq_31x32: table of hand-computed products,
// followed by directed sequences for back-pressure, abort and async reset.
module tb_mul_seq_31x32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_a;
    logic [31:0] in_b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [62:0] out_p;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mul_seq_31x32 #(.A_W(31), .SLICE_W(8), .B_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] a;
        logic [31:0] b;
        logic [62:0] p;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes we are #1 after an edge and the DUT is ready; the accept edge is consumed.
    task automatic accept_op(input logic [30:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        // Scribble the operand inputs: they must only be sampled on accept.
        in_a     = 31'h2AAA_5555;
        in_b     = 32'hDEAD_BEEF;
    endtask

    // Count edges from the accept edge until out_valid, and busy samples seen meanwhile.
    task automatic wait_result(output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (!out_valid && edges < 20) begin
            if (busy) busy_n++;
            tick();
            edges++;
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({name, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int          edges;
        int          busy_n;
        int          n;
        logic        stable_ok;
        logic        seen_valid;
        logic [62:0] held_p;

        vecs[0] = '{31'h0000_0001, 32'h0000_0001, 63'h0000_0000_0000_0001, "one_x_one"};
        vecs[1] = '{31'h7FFF_FFFF, 32'h0000_0001, 63'h7FFF_FFFF_FFFF_FFFF, "neg1_x_1"};
        vecs[2] = '{31'h3FFF_FFFF, 32'h7FFF_FFFF, 63'h1FFF_FFFF_4000_0001, "maxpos_x_maxpos"};
        vecs[3] = '{31'h4000_0000, 32'h8000_0000, 63'h2000_0000_0000_0000, "minneg_x_minneg"};
        vecs[4] = '{31'h4000_0000, 32'h0000_00FF, 63'h7FFF_FFC0_4000_0000, "minneg_x_255"};
        vecs[5] = '{31'h4000_0000, 32'h7FFF_FFFF, 63'h6000_0000_4000_0000, "minneg_x_maxpos"};
        vecs[6] = '{31'h3FFF_FFFF, 32'h8000_0000, 63'h6000_0000_8000_0000, "maxpos_x_minneg"};
        vecs[7] = '{31'h0000_007B, 32'hFFFF_FFFF, 63'h7FFF_FFFF_FFFF_FF85, "123_x_neg1"};
        vecs[8] = '{31'h0001_2345, 32'h0000_0100, 63'h0000_0000_0123_4500, "shift_slice1"};
        vecs[9] = '{31'h0000_0000, 32'h8765_4321, 63'h0, "zero_a"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_out_p",     {1'b0, out_p},      64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        rst = 1'b0;
        tick();

        // Table-driven products with latency and busy-width checks.
        foreach (vecs[i]) begin
            accept_op(vecs[i].a, vecs[i].b);
            wait_result(edges, busy_n);
            check({vecs[i].name, "_latency"}, 64'(edges), 64'd4);
            check({vecs[i].name, "_busy_cycles"}, 64'(busy_n), 64'd4);
            check({vecs[i].name, "_product"}, {1'b0, out_p}, {1'b0, vecs[i].p});
            handshake(vecs[i].name);
        end

        // Back-pressure in DONE, then back-to-back accept on the release edge.
        accept_op(31'd5, 32'd7);
        wait_result(edges, busy_n);
        check("bp_product", {1'b0, out_p}, 64'd35);
        held_p    = out_p;
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!out_valid || out_p !== held_p || in_ready) stable_ok = 1'b0;
        end
        check("bp_stable_10_cycles", {63'd0, stable_ok}, 64'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 31'h7FFF_FFFF;
        in_b      = 32'd2;
        #1;
        check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        check("b2b_valid_drop", {63'd0, out_valid}, 64'd0);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_result(edges, busy_n);
        check("b2b_latency", 64'(edges), 64'd4);
        check("b2b_product", {1'b0, out_p}, 64'h7FFF_FFFF_FFFF_FFFE);
        handshake("b2b");

        // Abort during slice k=2: no result may ever appear.
        accept_op(31'd9, 32'd9);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run_busy", {63'd0, busy}, 64'd0);
        check("abort_run_in_ready", {63'd0, in_ready}, 64'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        check("abort_run_no_valid", {63'd0, seen_valid}, 64'd0);

        // Abort coinciding with an accept: operands are not taken.
        in_valid = 1'b1;
        in_a     = 31'd4;
        in_b     = 32'd4;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_accept_busy", {63'd0, busy}, 64'd0);

        // Abort in DONE drops the pending result without a handshake.
        accept_op(31'd6, 32'd7);
        wait_result(edges, busy_n);
        check("abort_done_product", {1'b0, out_p}, 64'd42);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_valid", {63'd0, out_valid}, 64'd0);
        check("abort_done_in_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset between edges mid-RUN.
        accept_op(31'd11, 32'd13);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_busy",      {63'd0, busy},      64'd0);
        check("arst_out_p",     {1'b0, out_p},      64'd0);
        check("arst_in_ready",  {63'd0, in_ready},  64'd1);
        #2;
        rst = 1'b0;
        tick();
        accept_op(31'd3, 32'hFFFF_FFFE);
        wait_result(edges, busy_n);
        check("post_rst_latency", 64'(edges), 64'd4);
        check("post_rst_product", {1'b0, out_p}, 64'h7FFF_FFFF_FFFF_FFFA);
        handshake("post_rst");

        // Result must persist after handshake.
        n = 0;
        tick();
        check("p_hold_after_hs", {1'b0, out_p}, 64'h7FFF_FFFF_FFFF_FFFA);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
